// File: rtl/d16_alu.sv
// -----------------------------------------------------------------------------
// d16_alu -- execute-stage ALU of the d16 CPU.
//
// On every cycle with en=1 the ALU evaluates one opcode and registers the
// complete result bundle: data/address, store data, register write enable,
// flags, stack pointer, branch decision and link-register write. With en=0
// every output holds. All outputs are registered (latency 1 clk) and are
// cleared asynchronously by rst_n.
//
// Operand A is rD_data. Operand B is immediate when en_imm=1, else rS_data.
//
// Ports
//   clk              in   1   clock, rising edge
//   rst_n            in   1   asynchronous active-low reset
//   en               in   1   stage enable; outputs hold when 0
//   alu_control      in   8   opcode
//   en_imm           in   1   1: B = immediate, 0: B = rS_data
//   rD_data          in  16   operand A / store or push data
//   rS_data          in  16   operand B; SP for PUSH/POP; base for LD/ST
//   immediate        in  16   immediate operand / displacement
//   condition        in   4   branch condition code
//   flags_in         in   4   current flags {V,N,Z,C}
//   mem_displacement in   1   LD/ST address = rS_data + immediate
//   out              out 16   result / memory address / branch target
//   mem_data         out 16   store/push data
//   write            out  1   register-file write enable for rD
//   flags_out        out  4   new flags {V,N,Z,C}
//   SP_out           out 16   new stack pointer (holds unless PUSH/POP)
//   should_branch    out  1   JMP/CALL taken
//   lr_wr_en         out  1   link-register write (CALL taken)
//
// There is no internal FSM: each enabled cycle is independent of the last,
// except that SP_out keeps its value across non-stack opcodes.
// -----------------------------------------------------------------------------
module d16_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  alu_control,
  input  logic        en_imm,
  input  logic [15:0] rD_data,
  input  logic [15:0] rS_data,
  input  logic [15:0] immediate,
  input  logic [3:0]  condition,
  input  logic [3:0]  flags_in,
  input  logic        mem_displacement,
  output logic [15:0] out,
  output logic [15:0] mem_data,
  output logic        write,
  output logic [3:0]  flags_out,
  output logic [15:0] SP_out,
  output logic        should_branch,
  output logic        lr_wr_en
);

  // Opcode map
  localparam logic [7:0] OPC_NOP  = 8'h00;
  localparam logic [7:0] OPC_ADD  = 8'h01;
  localparam logic [7:0] OPC_SUB  = 8'h02;
  localparam logic [7:0] OPC_PUSH = 8'h03;
  localparam logic [7:0] OPC_POP  = 8'h04;
  localparam logic [7:0] OPC_MOV  = 8'h05;
  localparam logic [7:0] OPC_AND  = 8'h06;
  localparam logic [7:0] OPC_OR   = 8'h07;
  localparam logic [7:0] OPC_XOR  = 8'h08;
  localparam logic [7:0] OPC_NOT  = 8'h09;
  localparam logic [7:0] OPC_NEG  = 8'h0A;
  localparam logic [7:0] OPC_LD   = 8'h0B;
  localparam logic [7:0] OPC_ST   = 8'h0C;
  localparam logic [7:0] OPC_CMP  = 8'h0D;
  localparam logic [7:0] OPC_JMP  = 8'h0E;
  localparam logic [7:0] OPC_CALL = 8'h0F;
  localparam logic [7:0] OPC_SHL  = 8'h10;
  localparam logic [7:0] OPC_SHR  = 8'h11;
  localparam logic [7:0] OPC_ROL  = 8'h12;
  localparam logic [7:0] OPC_ADC  = 8'h13;
  localparam logic [7:0] OPC_SBB  = 8'h14;

  // Flag bit positions inside {V,N,Z,C}
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  // Branch condition evaluation against the incoming flags.
  function automatic logic cond_met(input logic [3:0] code, input logic [3:0] fl);
    logic c, z, n, v;
    c = fl[FLAG_C];
    z = fl[FLAG_Z];
    n = fl[FLAG_N];
    v = fl[FLAG_V];
    case (code)
      4'h0:    cond_met = 1'b0;             // NV
      4'h1:    cond_met = z;                // EQ
      4'h2:    cond_met = ~z;               // NE
      4'h3:    cond_met = v;                // OS
      4'h4:    cond_met = ~v;               // OC
      4'h5:    cond_met = c & ~z;           // HI
      4'h6:    cond_met = ~c | z;           // LS
      4'h7:    cond_met = ~n;               // P
      4'h8:    cond_met = n;                // N
      4'h9:    cond_met = c;                // CS
      4'hA:    cond_met = ~c;               // CC
      4'hB:    cond_met = (n == v);         // GE
      4'hC:    cond_met = ~z & (n == v);    // GT
      4'hD:    cond_met = z | (n != v);     // LE
      4'hE:    cond_met = (n != v);         // LT
      default: cond_met = 1'b1;             // AL
    endcase
  endfunction

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  shamt;
  logic        carry_in;

  // 17-bit arithmetic results; bit 16 is carry (add) or borrow (subtract).
  logic [16:0] add_res;
  logic [16:0] sub_res;
  logic [16:0] neg_res;
  logic [15:0] rol_res;
  logic [15:0] ldst_addr;

  logic [15:0] nxt_out;
  logic [15:0] nxt_mem_data;
  logic        nxt_write;
  logic [3:0]  nxt_flags;
  logic [15:0] nxt_sp;
  logic        nxt_branch;
  logic        nxt_lr;

  assign op_a     = rD_data;
  assign op_b     = en_imm ? immediate : rS_data;
  assign shamt    = op_b[3:0];
  assign carry_in = flags_in[FLAG_C];

  // ADD and ADC share one adder: carry_in is gated in only for ADC.
  // SUB, SBB and CMP share one subtractor the same way.
  always_comb begin
    add_res = {1'b0, op_a} + {1'b0, op_b}
              + {16'd0, (alu_control == OPC_ADC) & carry_in};
    sub_res = {1'b0, op_a} - {1'b0, op_b}
              - {16'd0, (alu_control == OPC_SBB) & carry_in};
    neg_res = 17'd0 - {1'b0, op_a};
    // Rotate left: the right shift by (16 - s) supplies the wrapped bits;
    // at s = 0 it shifts by 16 and contributes nothing.
    rol_res = (op_a << shamt) | (op_a >> (5'd16 - {1'b0, shamt}));
    ldst_addr = mem_displacement ? (rS_data + immediate) : rS_data;
  end

  // Flag builders
  function automatic logic [3:0] add_flags(input logic [15:0] a, input logic [15:0] b,
                                           input logic [16:0] r);
    logic v;
    v = (a[15] == b[15]) && (r[15] != a[15]);
    add_flags = {v, r[15], (r[15:0] == 16'd0), r[16]};
  endfunction

  function automatic logic [3:0] sub_flags(input logic [15:0] a, input logic [15:0] b,
                                           input logic [16:0] r);
    logic v;
    v = (a[15] != b[15]) && (r[15] != a[15]);
    sub_flags = {v, r[15], (r[15:0] == 16'd0), r[16]};
  endfunction

  function automatic logic [3:0] logic_flags(input logic [15:0] r);
    logic_flags = {1'b0, r[15], (r == 16'd0), 1'b0};
  endfunction

  // Next-state for every registered output. Fields not driven by the
  // selected opcode default to 0; flags pass through; SP holds.
  always_comb begin
    nxt_out      = 16'd0;
    nxt_mem_data = 16'd0;
    nxt_write    = 1'b0;
    nxt_flags    = flags_in;
    nxt_sp       = SP_out;
    nxt_branch   = 1'b0;
    nxt_lr       = 1'b0;

    case (alu_control)
      OPC_NOP: begin
        // defaults only
      end
      OPC_ADD, OPC_ADC: begin
        nxt_out   = add_res[15:0];
        nxt_write = 1'b1;
        nxt_flags = add_flags(op_a, op_b, add_res);
      end
      OPC_SUB, OPC_SBB: begin
        nxt_out   = sub_res[15:0];
        nxt_write = 1'b1;
        nxt_flags = sub_flags(op_a, op_b, sub_res);
      end
      OPC_CMP: begin
        nxt_out   = sub_res[15:0];
        nxt_flags = sub_flags(op_a, op_b, sub_res);
      end
      OPC_NEG: begin
        nxt_out   = neg_res[15:0];
        nxt_write = 1'b1;
        nxt_flags = sub_flags(16'd0, op_a, neg_res);
      end
      OPC_PUSH: begin
        nxt_out      = rS_data - 16'd2;
        nxt_sp       = rS_data - 16'd2;
        nxt_mem_data = rD_data;
      end
      OPC_POP: begin
        nxt_out   = rS_data;
        nxt_sp    = rS_data + 16'd2;
        nxt_write = 1'b1;
      end
      OPC_MOV: begin
        nxt_out   = op_b;
        nxt_write = 1'b1;
      end
      OPC_AND: begin
        nxt_out   = op_a & op_b;
        nxt_write = 1'b1;
        nxt_flags = logic_flags(op_a & op_b);
      end
      OPC_OR: begin
        nxt_out   = op_a | op_b;
        nxt_write = 1'b1;
        nxt_flags = logic_flags(op_a | op_b);
      end
      OPC_XOR: begin
        nxt_out   = op_a ^ op_b;
        nxt_write = 1'b1;
        nxt_flags = logic_flags(op_a ^ op_b);
      end
      OPC_NOT: begin
        nxt_out   = ~op_a;
        nxt_write = 1'b1;
        nxt_flags = logic_flags(~op_a);
      end
      OPC_SHL: begin
        nxt_out   = op_a << shamt;
        nxt_write = 1'b1;
        nxt_flags = logic_flags(op_a << shamt);
      end
      OPC_SHR: begin
        nxt_out   = op_a >> shamt;
        nxt_write = 1'b1;
        nxt_flags = logic_flags(op_a >> shamt);
      end
      OPC_ROL: begin
        nxt_out   = rol_res;
        nxt_write = 1'b1;
        nxt_flags = logic_flags(rol_res);
      end
      OPC_LD: begin
        nxt_out   = ldst_addr;
        nxt_write = 1'b1;
      end
      OPC_ST: begin
        nxt_out      = ldst_addr;
        nxt_mem_data = rD_data;
      end
      OPC_JMP: begin
        nxt_out    = op_b;
        nxt_branch = cond_met(condition, flags_in);
      end
      OPC_CALL: begin
        nxt_out    = op_b;
        nxt_branch = cond_met(condition, flags_in);
        nxt_lr     = cond_met(condition, flags_in);
      end
      default: begin
        // unknown opcode: behaves as NOP
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out           <= 16'd0;
      mem_data      <= 16'd0;
      write         <= 1'b0;
      flags_out     <= 4'd0;
      SP_out        <= 16'd0;
      should_branch <= 1'b0;
      lr_wr_en      <= 1'b0;
    end else if (en) begin
      out           <= nxt_out;
      mem_data      <= nxt_mem_data;
      write         <= nxt_write;
      flags_out     <= nxt_flags;
      SP_out        <= nxt_sp;
      should_branch <= nxt_branch;
      lr_wr_en      <= nxt_lr;
    end
  end

endmodule

// File: tb/tb_d16_alu.sv
// -----------------------------------------------------------------------------
// tb_d16_alu -- directed self-checking bench for d16_alu.
// Each step drives one opcode, pushes the hand-derived expected result bundle
// onto exp_q, clocks once and pops/compares every output field.
// Expected bundle layout: {out[16], mem_data[16], SP_out[16], flags[4],
//                          write, should_branch, lr_wr_en} = 55 bits.
// -----------------------------------------------------------------------------
module tb_d16_alu;

  localparam int W = 55;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  alu_control;
  logic        en_imm;
  logic [15:0] rD_data;
  logic [15:0] rS_data;
  logic [15:0] immediate;
  logic [3:0]  condition;
  logic [3:0]  flags_in;
  logic        mem_displacement;
  logic [15:0] out;
  logic [15:0] mem_data;
  logic        write;
  logic [3:0]  flags_out;
  logic [15:0] SP_out;
  logic        should_branch;
  logic        lr_wr_en;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  int total;
  int bad;

  d16_alu dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .en               (en),
    .alu_control      (alu_control),
    .en_imm           (en_imm),
    .rD_data          (rD_data),
    .rS_data          (rS_data),
    .immediate        (immediate),
    .condition        (condition),
    .flags_in         (flags_in),
    .mem_displacement (mem_displacement),
    .out              (out),
    .mem_data         (mem_data),
    .write            (write),
    .flags_out        (flags_out),
    .SP_out           (SP_out),
    .should_branch    (should_branch),
    .lr_wr_en         (lr_wr_en)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pk(input logic [15:0] o, input logic [15:0] m,
                                      input logic [15:0] sp, input logic [3:0] fl,
                                      input logic wr, input logic br, input logic lr);
    pk = {o, m, sp, fl, wr, br, lr};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] e);
    check({tag, ".out"},      out,                     e[54:39]);
    check({tag, ".mem_data"}, mem_data,                e[38:23]);
    check({tag, ".SP_out"},   SP_out,                  e[22:7]);
    check({tag, ".flags"},    {12'd0, flags_out},      {12'd0, e[6:3]});
    check({tag, ".write"},    {15'd0, write},          {15'd0, e[2]});
    check({tag, ".branch"},   {15'd0, should_branch},  {15'd0, e[1]});
    check({tag, ".lr_wr_en"}, {15'd0, lr_wr_en},       {15'd0, e[0]});
  endtask

  // Clock once, then pop the oldest expectation and compare.
  task automatic clock_and_score(input string tag);
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_all(tag, e);
    end
  endtask

  // Driver: one enabled opcode with its expected result bundle.
  task automatic op(input string tag, input logic [7:0] o, input logic ei,
                    input logic [15:0] rd, input logic [15:0] rs, input logic [15:0] im,
                    input logic [3:0] cnd, input logic [3:0] fl, input logic dsp,
                    input logic [15:0] e_out, input logic [15:0] e_mem,
                    input logic [15:0] e_sp, input logic [3:0] e_fl,
                    input logic e_wr, input logic e_br, input logic e_lr);
    en               = 1'b1;
    alu_control      = o;
    en_imm           = ei;
    rD_data          = rd;
    rS_data          = rs;
    immediate        = im;
    condition        = cnd;
    flags_in         = fl;
    mem_displacement = dsp;
    last_exp = pk(e_out, e_mem, e_sp, e_fl, e_wr, e_br, e_lr);
    exp_q.push_back(last_exp);
    clock_and_score(tag);
  endtask

  // Driver: en=0 with random inputs; the previous bundle must hold.
  task automatic hold_cycle(input string tag);
    en               = 1'b0;
    alu_control      = 8'($urandom_range(1, 20));
    en_imm           = 1'($urandom_range(0, 1));
    rD_data          = 16'($urandom_range(0, 65535));
    rS_data          = 16'($urandom_range(0, 65535));
    immediate        = 16'($urandom_range(0, 65535));
    condition        = 4'($urandom_range(0, 15));
    flags_in         = 4'($urandom_range(0, 15));
    mem_displacement = 1'($urandom_range(0, 1));
    exp_q.push_back(last_exp);
    clock_and_score(tag);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en = 1'b0; alu_control = 8'h00; en_imm = 1'b0;
    rD_data = 16'd0; rS_data = 16'd0; immediate = 16'd0;
    condition = 4'd0; flags_in = 4'd0; mem_displacement = 1'b0;

    #12;
    check_all("reset", '0);
    rst_n = 1'b1;

    //  tag         opc    ei  rD       rS       imm      cnd   fl       dsp  out      mem      sp       flags    wr br lr
    op("add",       8'h01, 0, 16'h0005, 16'h0002, 16'h0000, 4'h0, 4'b0000, 0, 16'h0007, 16'h0000, 16'h0000, 4'b0000, 1, 0, 0);
    op("sub",       8'h02, 0, 16'h0005, 16'h0002, 16'h0000, 4'h0, 4'b0000, 0, 16'h0003, 16'h0000, 16'h0000, 4'b0000, 1, 0, 0);
    op("mov_imm",   8'h05, 1, 16'h1234, 16'h5678, 16'h001d, 4'h0, 4'b0101, 0, 16'h001d, 16'h0000, 16'h0000, 4'b0101, 1, 0, 0);
    op("add_ovf",   8'h01, 1, 16'h7fff, 16'h0000, 16'h0001, 4'h0, 4'b0000, 0, 16'h8000, 16'h0000, 16'h0000, 4'b1100, 1, 0, 0);
    op("and",       8'h06, 0, 16'h0fa5, 16'h1d3c, 16'h0000, 4'h0, 4'b1111, 0, 16'h0d24, 16'h0000, 16'h0000, 4'b0000, 1, 0, 0);
    op("or",        8'h07, 0, 16'h0fa5, 16'h1d3c, 16'h0000, 4'h0, 4'b0000, 0, 16'h1fbd, 16'h0000, 16'h0000, 4'b0000, 1, 0, 0);
    op("xor",       8'h08, 0, 16'h0fa5, 16'h1d3c, 16'h0000, 4'h0, 4'b0000, 0, 16'h1299, 16'h0000, 16'h0000, 4'b0000, 1, 0, 0);
    op("not",       8'h09, 0, 16'h0fa5, 16'h1d3c, 16'h0000, 4'h0, 4'b1001, 0, 16'hf05a, 16'h0000, 16'h0000, 4'b0100, 1, 0, 0);
    op("shl",       8'h10, 1, 16'h0fa5, 16'h0000, 16'h0003, 4'h0, 4'b0000, 0, 16'h7d28, 16'h0000, 16'h0000, 4'b0000, 1, 0, 0);
    op("shr",       8'h11, 1, 16'h0fa5, 16'h0000, 16'h0003, 4'h0, 4'b0000, 0, 16'h01f4, 16'h0000, 16'h0000, 4'b0000, 1, 0, 0);
    op("rol",       8'h12, 1, 16'h0fa5, 16'h0000, 16'h0006, 4'h0, 4'b0000, 0, 16'he943, 16'h0000, 16'h0000, 4'b0100, 1, 0, 0);
    op("adc",       8'h13, 1, 16'h0001, 16'h0000, 16'h0006, 4'h0, 4'b0001, 0, 16'h0008, 16'h0000, 16'h0000, 4'b0000, 1, 0, 0);
    op("push",      8'h03, 0, 16'h0567, 16'h0100, 16'h0000, 4'h0, 4'b0010, 0, 16'h00fe, 16'h0567, 16'h00fe, 4'b0010, 0, 0, 0);
    op("pop",       8'h04, 0, 16'h0000, 16'h00fe, 16'h0000, 4'h0, 4'b0000, 0, 16'h00fe, 16'h0000, 16'h0100, 4'b0000, 1, 0, 0);
    op("sub_borrow",8'h02, 0, 16'h0002, 16'h0005, 16'h0000, 4'h0, 4'b0000, 0, 16'hfffd, 16'h0000, 16'h0100, 4'b0101, 1, 0, 0);
    op("cmp_eq",    8'h0D, 0, 16'h0005, 16'h0005, 16'h0000, 4'h0, 4'b0000, 0, 16'h0000, 16'h0000, 16'h0100, 4'b0010, 0, 0, 0);
    op("sbb",       8'h14, 0, 16'h0005, 16'h0002, 16'h0000, 4'h0, 4'b0001, 0, 16'h0002, 16'h0000, 16'h0100, 4'b0000, 1, 0, 0);
    op("neg_min",   8'h0A, 0, 16'h8000, 16'h0000, 16'h0000, 4'h0, 4'b0000, 0, 16'h8000, 16'h0000, 16'h0100, 4'b1101, 1, 0, 0);
    op("neg_zero",  8'h0A, 0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'b0000, 0, 16'h0000, 16'h0000, 16'h0100, 4'b0010, 1, 0, 0);
    op("add_carry", 8'h01, 1, 16'hffff, 16'h0000, 16'h0001, 4'h0, 4'b0000, 0, 16'h0000, 16'h0000, 16'h0100, 4'b0011, 1, 0, 0);
    op("ld_disp",   8'h0B, 0, 16'h0000, 16'h1000, 16'h0010, 4'h0, 4'b1000, 1, 16'h1010, 16'h0000, 16'h0100, 4'b1000, 1, 0, 0);
    op("ld_base",   8'h0B, 0, 16'h0000, 16'h1000, 16'h0010, 4'h0, 4'b0000, 0, 16'h1000, 16'h0000, 16'h0100, 4'b0000, 1, 0, 0);
    op("st_disp",   8'h0C, 0, 16'habcd, 16'h2000, 16'h0004, 4'h0, 4'b0000, 1, 16'h2004, 16'habcd, 16'h0100, 4'b0000, 0, 0, 0);

    hold_cycle("hold1");
    hold_cycle("hold2");

    op("jmp_eq_nz", 8'h0E, 1, 16'h0000, 16'h0000, 16'h0400, 4'h1, 4'b0000, 0, 16'h0400, 16'h0000, 16'h0100, 4'b0000, 0, 0, 0);
    op("jmp_eq_z",  8'h0E, 1, 16'h0000, 16'h0000, 16'h0400, 4'h1, 4'b0010, 0, 16'h0400, 16'h0000, 16'h0100, 4'b0010, 0, 1, 0);
    op("call_al",   8'h0F, 0, 16'h0000, 16'h0800, 16'h0000, 4'hF, 4'b0000, 0, 16'h0800, 16'h0000, 16'h0100, 4'b0000, 0, 1, 1);
    op("call_ge_n", 8'h0F, 1, 16'h0000, 16'h0000, 16'h0900, 4'hB, 4'b0100, 0, 16'h0900, 16'h0000, 16'h0100, 4'b0100, 0, 0, 0);
    op("jmp_gt_v",  8'h0E, 1, 16'h0000, 16'h0000, 16'h0a00, 4'hC, 4'b1000, 0, 16'h0a00, 16'h0000, 16'h0100, 4'b1000, 0, 0, 0);
    op("jmp_le_v",  8'h0E, 1, 16'h0000, 16'h0000, 16'h0a00, 4'hD, 4'b1000, 0, 16'h0a00, 16'h0000, 16'h0100, 4'b1000, 0, 1, 0);
    op("jmp_hi",    8'h0E, 1, 16'h0000, 16'h0000, 16'h0b00, 4'h5, 4'b0001, 0, 16'h0b00, 16'h0000, 16'h0100, 4'b0001, 0, 1, 0);
    op("jmp_nv",    8'h0E, 1, 16'h0000, 16'h0000, 16'h0b00, 4'h0, 4'b1111, 0, 16'h0b00, 16'h0000, 16'h0100, 4'b1111, 0, 0, 0);
    op("nop",       8'h00, 0, 16'h1111, 16'h2222, 16'h3333, 4'hF, 4'b0110, 1, 16'h0000, 16'h0000, 16'h0100, 4'b0110, 0, 0, 0);

    // Asynchronous reset between clock edges clears every output at once.
    rst_n = 1'b0;
    #1;
    check_all("async_reset", '0);
    #1;
    rst_n = 1'b1;

    op("add_after_rst", 8'h01, 0, 16'h0005, 16'h0002, 16'h0000, 4'h0, 4'b0000, 0, 16'h0007, 16'h0000, 16'h0000, 4'b0000, 1, 0, 0);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
